// File: rtl/uart_buffered_controller.sv
// Byte FIFOs between a UART receiver/transmitter pair and a core-side handshake interface.
// Optional: define UART_CONTROLLER_LOST_STICKY_EN to make the RX overflow flag sticky until reset.
module uart_buffered_controller #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  output logic              recv_reset,
  input  logic [7:0]        recv_data,
  input  logic              recv_ok,
  output logic              trans_reset,
  output logic [7:0]        trans_data,
  output logic              trans_ok,
  input  logic              trans_busy,
  input  logic [7:0]        uart_in_data,
  input  logic              uart_in_valid,
  output logic              uart_in_ready,
  input  logic              uart_out_valid,
  output logic [7:0]        uart_out_data,
  output logic              uart_out_ready,
  output logic [ADDR_W-1:0] in_buffer_length,
  output logic [ADDR_W-1:0] out_buffer_length,
  output logic              lost
);

  localparam int              DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] FULL_LVL = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  // Index 0 is the RX FIFO, index 1 the TX FIFO.
  logic              w_push  [2];
  logic              w_pop   [2];
  logic              w_full  [2];
  logic              w_empty [2];
  logic [7:0]        w_din   [2];
  logic [7:0]        w_head  [2];
  logic [ADDR_W-1:0] w_level [2];
  logic              w_drop;

  logic              r_recv_reset;
  logic              r_trans_reset;
  logic [7:0]        r_trans_data;
  logic              r_trans_ok;
  logic              r_uart_in_ready;
  logic [7:0]        r_uart_out_data;
  logic              r_uart_out_ready;
  logic              r_lost;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]        r_mem [DEPTH];
      logic [ADDR_W-1:0] r_wr;
      logic [ADDR_W-1:0] r_rd;

      always_ff @(posedge clk) begin
        if (w_push[gi]) r_mem[r_wr] <= w_din[gi];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_wr <= '0;
          r_rd <= '0;
        end else begin
          if (w_push[gi]) r_wr <= r_wr + PTR_ONE;
          if (w_pop[gi])  r_rd <= r_rd + PTR_ONE;
        end
      end

      // One slot stays unused so the pointer difference alone gives occupancy.
      assign w_level[gi] = r_wr - r_rd;
      assign w_full[gi]  = (w_level[gi] == FULL_LVL);
      assign w_empty[gi] = (w_level[gi] == '0);
      assign w_head[gi]  = r_mem[r_rd];
    end
  endgenerate

  assign w_din[0]  = recv_data;
  assign w_push[0] = recv_ok & ~w_full[0];
  assign w_pop[0]  = uart_out_valid & ~r_uart_out_ready & ~w_empty[0];
  assign w_drop    = recv_ok & w_full[0];

  assign w_din[1]  = uart_in_data;
  assign w_push[1] = uart_in_valid & ~r_uart_in_ready & ~w_full[1];
  assign w_pop[1]  = ~trans_busy & ~r_trans_ok & ~w_empty[1];

  always_ff @(posedge clk) begin
    r_recv_reset  <= reset;
    r_trans_reset <= reset;
    if (reset) begin
      r_trans_data     <= '0;
      r_trans_ok       <= 1'b0;
      r_uart_in_ready  <= 1'b0;
      r_uart_out_data  <= '0;
      r_uart_out_ready <= 1'b0;
      r_lost           <= 1'b0;
    end else begin
      r_uart_out_ready <= w_pop[0];
      if (w_pop[0]) r_uart_out_data <= w_head[0];
      r_uart_in_ready  <= w_push[1];
      r_trans_ok       <= w_pop[1];
      if (w_pop[1]) r_trans_data <= w_head[1];
`ifdef UART_CONTROLLER_LOST_STICKY_EN
      r_lost <= r_lost | w_drop;
`else
      r_lost <= w_drop;
`endif
    end
  end

  assign recv_reset        = r_recv_reset;
  assign trans_reset       = r_trans_reset;
  assign trans_data        = r_trans_data;
  assign trans_ok          = r_trans_ok;
  assign uart_in_ready     = r_uart_in_ready;
  assign uart_out_data     = r_uart_out_data;
  assign uart_out_ready    = r_uart_out_ready;
  assign in_buffer_length  = w_level[1];
  assign out_buffer_length = w_level[0];
  assign lost              = r_lost;

endmodule

// File: tb/tb_uart_buffered_controller.sv
// Randomised and directed bench for uart_buffered_controller against a queue-based reference model.
module tb_uart_buffered_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       recv_reset, trans_reset;
  logic [7:0] recv_data = '0;
  logic       recv_ok = 1'b0;
  logic [7:0] trans_data;
  logic       trans_ok;
  logic       trans_busy = 1'b0;
  logic [7:0] uart_in_data = '0;
  logic       uart_in_valid = 1'b0;
  logic       uart_in_ready;
  logic       uart_out_valid = 1'b0;
  logic [7:0] uart_out_data;
  logic       uart_out_ready;
  logic [2:0] in_buffer_length, out_buffer_length;
  logic       lost;

  always #5 clk = ~clk;

  uart_buffered_controller #(.ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .recv_reset(recv_reset), .recv_data(recv_data),
    .recv_ok(recv_ok), .trans_reset(trans_reset), .trans_data(trans_data),
    .trans_ok(trans_ok), .trans_busy(trans_busy), .uart_in_data(uart_in_data),
    .uart_in_valid(uart_in_valid), .uart_in_ready(uart_in_ready),
    .uart_out_valid(uart_out_valid), .uart_out_data(uart_out_data),
    .uart_out_ready(uart_out_ready), .in_buffer_length(in_buffer_length),
    .out_buffer_length(out_buffer_length), .lost(lost)
  );

  // Reference model: byte queues plus the expected registered outputs.
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic       e_rst = 1'b0;
  logic       e_out_ready = 1'b0, e_in_ready = 1'b0, e_trans_ok = 1'b0, e_lost = 1'b0;
  logic [7:0] e_out_data = '0, e_trans_data = '0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_drops = 0;

  // Apply one clock: update the model from the current inputs, then advance the DUT.
  task automatic tick();
    bit rx_full, rx_empty, tx_full, tx_empty, rd, wr, tx, drop;
    rx_full  = (rxq.size() == 7);
    rx_empty = (rxq.size() == 0);
    tx_full  = (txq.size() == 7);
    tx_empty = (txq.size() == 0);
    if (reset) begin
      rxq.delete();
      txq.delete();
      e_out_ready = 0; e_in_ready = 0; e_trans_ok = 0; e_lost = 0;
      e_out_data = '0; e_trans_data = '0;
    end else begin
      rd   = uart_out_valid && !e_out_ready && !rx_empty;
      wr   = uart_in_valid && !e_in_ready && !tx_full;
      tx   = !trans_busy && !e_trans_ok && !tx_empty;
      drop = recv_ok && rx_full;
      e_out_ready = rd;
      if (rd) e_out_data = rxq.pop_front();
      if (recv_ok && !rx_full) rxq.push_back(recv_data);
      e_in_ready = wr;
      if (wr) txq.push_back(uart_in_data);
      e_trans_ok = tx;
      if (tx) e_trans_data = txq.pop_front();
      if (drop) n_drops++;
`ifdef UART_CONTROLLER_LOST_STICKY_EN
      e_lost = e_lost | drop;
`else
      e_lost = drop;
`endif
    end
    e_rst = reset;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (recv_reset !== 1'b1 || trans_reset !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_out: recv_reset=%0b trans_reset=%0b want 1/1", recv_reset, trans_reset);
      end
    end
    n_checks++;
    if (in_buffer_length !== 3'd0 || out_buffer_length !== 3'd0 || lost !== 1'b0 ||
        uart_out_ready !== 1'b0 || uart_in_ready !== 1'b0 || trans_ok !== 1'b0 ||
        trans_data !== 8'h00 || uart_out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: inlen=%0d outlen=%0d lost=%0b ordy=%0b irdy=%0b tok=%0b td=%h od=%h want all 0",
               in_buffer_length, out_buffer_length, lost, uart_out_ready, uart_in_ready,
               trans_ok, trans_data, uart_out_data);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (recv_reset !== 1'b0 || trans_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: recv_reset=%0b trans_reset=%0b want 0/0", recv_reset, trans_reset);
    end
  endtask

  task automatic rx_read(input int cycles);
    uart_out_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      n_checks++;
      if (uart_out_ready !== e_out_ready || uart_out_data !== e_out_data) begin
        n_fail++;
        $display("FAIL rx_read: ready=%0b data=%h want ready=%0b data=%h",
                 uart_out_ready, uart_out_data, e_out_ready, e_out_data);
      end
    end
    uart_out_valid = 1'b0;
  endtask

  task automatic test_rx_order();
    logic [7:0] seq [3] = '{8'hB3, 8'h5F, 8'hAA};
    for (int i = 0; i < 3; i++) begin
      recv_data = seq[i]; recv_ok = 1'b1; tick();
      recv_ok = 1'b0; tick();
    end
    n_checks++;
    if (out_buffer_length !== 3'd3) begin
      n_fail++;
      $display("FAIL rx_len3: got %0d want 3", out_buffer_length);
    end
    rx_read(4);
    recv_data = 8'h0F; recv_ok = 1'b1; tick(); recv_ok = 1'b0;
    rx_read(5);
  endtask

  task automatic test_rx_overflow();
    int drops_before;
    drops_before = n_drops;
    for (int i = 0; i < 12; i++) begin
      recv_data = (i < 4) ? 8'hB3 : 8'h4C;
      recv_ok = 1'b1;
      tick();
      n_checks++;
      if (out_buffer_length !== 3'(rxq.size()) || lost !== e_lost) begin
        n_fail++;
        $display("FAIL rx_overflow: len=%0d lost=%0b want len=%0d lost=%0b",
                 out_buffer_length, lost, rxq.size(), e_lost);
      end
    end
    recv_ok = 1'b0;
    n_checks++;
    if (n_drops - drops_before != 5) begin
      n_fail++;
      $display("FAIL rx_drop_count: model drops=%0d want 5", n_drops - drops_before);
    end
    rx_read(18);
  endtask

  task automatic tx_write(input logic [7:0] b);
    uart_in_data = b; uart_in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (uart_in_ready !== e_in_ready || in_buffer_length !== 3'(txq.size())) begin
        n_fail++;
        $display("FAIL tx_write: ready=%0b len=%0d want ready=%0b len=%0d",
                 uart_in_ready, in_buffer_length, e_in_ready, txq.size());
      end
    end
    uart_in_valid = 1'b0;
  endtask

  task automatic tx_drain(input int cycles);
    trans_busy = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      n_checks++;
      if (trans_ok !== e_trans_ok || trans_data !== e_trans_data) begin
        n_fail++;
        $display("FAIL tx_drain: ok=%0b data=%h want ok=%0b data=%h",
                 trans_ok, trans_data, e_trans_ok, e_trans_data);
      end
    end
  endtask

  task automatic test_tx_basic();
    trans_busy = 1'b1;
    tx_write(8'h5A); tx_write(8'hA5); tx_write(8'hE3); tx_write(8'h1C);
    tx_drain(10);
  endtask

  task automatic test_tx_full();
    trans_busy = 1'b1;
    tx_write(8'h5A);
    for (int i = 0; i < 6; i++) tx_write(8'($urandom_range(0, 254)));
    uart_in_data = 8'hFF; uart_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (uart_in_ready !== e_in_ready || in_buffer_length !== 3'(txq.size())) begin
        n_fail++;
        $display("FAIL tx_full_stall: ready=%0b len=%0d want ready=%0b len=%0d",
                 uart_in_ready, in_buffer_length, e_in_ready, txq.size());
      end
    end
    trans_busy = 1'b0; tick(); trans_busy = 1'b1;
    n_checks++;
    if (trans_ok !== e_trans_ok || trans_data !== e_trans_data) begin
      n_fail++;
      $display("FAIL tx_full_pop: ok=%0b data=%h want ok=%0b data=%h",
               trans_ok, trans_data, e_trans_ok, e_trans_data);
    end
    tick();
    n_checks++;
    if (uart_in_ready !== e_in_ready) begin
      n_fail++;
      $display("FAIL tx_full_resume: ready=%0b want %0b", uart_in_ready, e_in_ready);
    end
    uart_in_valid = 1'b0;
    tx_drain(18);
  endtask

  task automatic test_simultaneous();
    trans_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      recv_data = 8'($urandom); recv_ok = 1'b1; tick(); recv_ok = 1'b0;
      tx_write(8'($urandom));
    end
    recv_data = 8'h3C; recv_ok = 1'b1; uart_out_valid = 1'b1;
    uart_in_data = 8'hC3; uart_in_valid = 1'b1; trans_busy = 1'b0;
    tick();
    recv_ok = 1'b0; uart_out_valid = 1'b0; uart_in_valid = 1'b0; trans_busy = 1'b1;
    n_checks++;
    if (out_buffer_length !== 3'(rxq.size()) || in_buffer_length !== 3'(txq.size()) ||
        lost !== e_lost || uart_out_ready !== e_out_ready || uart_in_ready !== e_in_ready ||
        trans_ok !== e_trans_ok || uart_out_data !== e_out_data || trans_data !== e_trans_data) begin
      n_fail++;
      $display("FAIL simultaneous: olen=%0d ilen=%0d lost=%0b ordy=%0b irdy=%0b tok=%0b od=%h td=%h want %0d %0d %0b %0b %0b %0b %h %h",
               out_buffer_length, in_buffer_length, lost, uart_out_ready, uart_in_ready, trans_ok,
               uart_out_data, trans_data, rxq.size(), txq.size(), e_lost, e_out_ready,
               e_in_ready, e_trans_ok, e_out_data, e_trans_data);
    end
    rx_read(8);
    tx_drain(8);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      reset          = ($urandom_range(0, 199) == 0);
      recv_ok        = ($urandom_range(0, 9) < 4);
      recv_data      = 8'($urandom);
      uart_out_valid = ($urandom_range(0, 9) < 3);
      uart_in_valid  = ($urandom_range(0, 9) < 5);
      uart_in_data   = 8'($urandom);
      trans_busy     = ($urandom_range(0, 9) < 6);
      tick();
      n_checks++;
      if (recv_reset !== e_rst || trans_reset !== e_rst ||
          uart_out_ready !== e_out_ready || uart_out_data !== e_out_data ||
          uart_in_ready !== e_in_ready || trans_ok !== e_trans_ok || trans_data !== e_trans_data ||
          out_buffer_length !== 3'(rxq.size()) || in_buffer_length !== 3'(txq.size()) ||
          lost !== e_lost) begin
        n_fail++;
        $display("FAIL random cyc %0d: rst=%0b/%0b ordy=%0b od=%h irdy=%0b tok=%0b td=%h olen=%0d ilen=%0d lost=%0b want rst=%0b ordy=%0b od=%h irdy=%0b tok=%0b td=%h olen=%0d ilen=%0d lost=%0b",
                 i, recv_reset, trans_reset, uart_out_ready, uart_out_data, uart_in_ready,
                 trans_ok, trans_data, out_buffer_length, in_buffer_length, lost,
                 e_rst, e_out_ready, e_out_data, e_in_ready, e_trans_ok, e_trans_data,
                 rxq.size(), txq.size(), e_lost);
      end
    end
    reset = 1'b0; recv_ok = 1'b0; uart_out_valid = 1'b0; uart_in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rx_order();
    test_rx_overflow();
    test_tx_basic();
    test_tx_full();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
